// File: rtl/rca_config_sequencer_pkg.sv
// Shared types for the RCA configuration sequencer: instruction encodings,
// queued entry layout and build-time configuration.
package rca_config_sequencer_pkg;

    localparam int CFG_NUM_RCAS = 3;
    localparam bit USE_RCA      = 1'b1;
    localparam int RCA_ID_W     = $clog2(CFG_NUM_RCAS);

    typedef enum logic [2:0] {
        CPU_REG      = 3'd2,
        GRID_MUX     = 3'd3,
        IO_MUX       = 3'd4,
        RESULT_MUX   = 3'd5,
        IO_INP_MAP   = 3'd6,
        INP_CONSTANT = 3'd7
    } rca_cfg_type_t;

    typedef struct packed {
        logic [2:0]          cfg_type;
        logic [RCA_ID_W-1:0] rca_id;
        logic [31:0]         addr;
        logic [31:0]         data;
    } cfg_entry_t;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_LOADED
    } slot_state_t;

    // Types 0 and 1 are the RCA_USE encodings and never reach the config port.
    function automatic logic is_cfg_type(input logic [2:0] t);
        return t >= CPU_REG;
    endfunction

endpackage

// File: rtl/rca_config_sequencer_fifo.sv
// Circular buffer of configuration entries; pointers carry a wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module rca_cfg_fifo
    import rca_config_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  cfg_entry_t push_entry,
    input  logic       pop,
    output cfg_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    cfg_entry_t       mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
    end

    assign head  = mem[rd_ptr[PTR_W-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/rca_config_sequencer.sv
// Queues decoded RCA configuration instructions and serialises them onto the
// shared config-write port while tracking per-unit outstanding configuration.
module rca_config_sequencer
    import rca_config_sequencer_pkg::*;
#(
    parameter int NUM_RCAS   = CFG_NUM_RCAS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_issue_valid,
    output logic                        cfg_issue_ready,
    input  logic [2:0]                  cfg_type,
    input  logic [$clog2(NUM_RCAS)-1:0] cfg_rca_id,
    input  logic [31:0]                 cfg_rs1,
    input  logic [31:0]                 cfg_rs2,
    input  logic                        cfg_flush,
    output logic                        cfg_wr_valid,
    input  logic                        cfg_wr_ready,
    output logic [2:0]                  cfg_wr_type,
    output logic [$clog2(NUM_RCAS)-1:0] cfg_wr_rca_id,
    output logic [31:0]                 cfg_wr_addr,
    output logic [31:0]                 cfg_wr_data,
    input  logic [$clog2(NUM_RCAS)-1:0] use_check_id,
    output logic                        use_blocked,
    output logic [NUM_RCAS-1:0]         rca_pending_mask,
    output logic                        cfg_type_error
);

    localparam int ID_W  = $clog2(NUM_RCAS);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    cfg_entry_t  fifo_head;
    cfg_entry_t  issue_entry;
    cfg_entry_t  slot_q;
    slot_state_t state_q;
    slot_state_t state_d;
    logic        load_head;
    logic        load_bypass;
    logic        accept;
    logic        legal;
    logic        push_legal;
    logic        wr_fire;
    logic        slot_free;

    logic [CNT_W-1:0]    pending   [NUM_RCAS];
    logic [CNT_W-1:0]    pending_d [NUM_RCAS];
    logic [NUM_RCAS-1:0] inc_vec;
    logic [NUM_RCAS-1:0] dec_vec;

    assign cfg_issue_ready = ~fifo_full & ~cfg_flush;
    assign accept          = cfg_issue_valid & cfg_issue_ready;
    assign legal           = USE_RCA && is_cfg_type(cfg_type) && (int'(cfg_rca_id) < NUM_RCAS);
    assign push_legal      = accept & legal;
    assign wr_fire         = cfg_wr_valid & cfg_wr_ready;
    assign slot_free       = (state_q == SLOT_EMPTY) || wr_fire;
    assign issue_entry     = '{cfg_type, cfg_rca_id, cfg_rs1, cfg_rs2};

    // An empty FIFO lets a new entry go straight into the slot so it is
    // presented the cycle after it is accepted.
    assign fifo_push = push_legal & ~load_bypass;

    rca_cfg_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (cfg_flush),
        .push       (fifo_push),
        .push_entry (issue_entry),
        .pop        (load_head),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= SLOT_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        load_head   = 1'b0;
        load_bypass = 1'b0;
        if (cfg_flush) begin
            state_d = SLOT_EMPTY;
        end else if (slot_free) begin
            if (!fifo_empty) begin
                load_head = 1'b1;
                state_d   = SLOT_LOADED;
            end else if (push_legal) begin
                load_bypass = 1'b1;
                state_d     = SLOT_LOADED;
            end else begin
                state_d = SLOT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           slot_q <= '0;
        else if (load_head)   slot_q <= fifo_head;
        else if (load_bypass) slot_q <= issue_entry;
    end

    assign cfg_wr_valid  = (state_q == SLOT_LOADED);
    assign cfg_wr_type   = slot_q.cfg_type;
    assign cfg_wr_rca_id = slot_q.rca_id;
    assign cfg_wr_addr   = slot_q.addr;
    assign cfg_wr_data   = slot_q.data;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NUM_RCAS; i++) begin
            inc_vec[i]   = push_legal && (cfg_rca_id == ID_W'(i));
            dec_vec[i]   = wr_fire && (cfg_wr_rca_id == ID_W'(i));
            pending_d[i] = pending[i];
            if (cfg_flush)                     pending_d[i] = '0;
            else if (inc_vec[i] && !dec_vec[i]) pending_d[i] = pending[i] + 1'b1;
            else if (dec_vec[i] && !inc_vec[i]) pending_d[i] = pending[i] - 1'b1;
        end
    end

    // The mask is registered from the next counter value so it always agrees
    // with the counters visible to use_blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RCAS; i++) pending[i] <= '0;
            rca_pending_mask <= '0;
            cfg_type_error   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RCAS; i++) begin
                if (inc_vec[i] && !dec_vec[i]) assert (pending[i] != CNT_MAX);
                if (dec_vec[i] && !inc_vec[i]) assert (pending[i] != '0);
                pending[i]          <= pending_d[i];
                rca_pending_mask[i] <= (pending_d[i] != '0);
            end
            cfg_type_error <= accept & ~legal;
        end
    end

    always_comb begin
        use_blocked = 1'b0;
        for (int i = 0; i < NUM_RCAS; i++) begin
            if (use_check_id == ID_W'(i)) use_blocked = (pending[i] != '0);
        end
    end

endmodule

// File: tb/tb_rca_config_sequencer.sv
// Scenario bench for rca_config_sequencer with a queue-based reference model.
module tb_rca_config_sequencer;

    localparam int NR  = 3;
    localparam int CAP = 5;

    logic        clk;
    logic        rst_n;
    logic        cfg_issue_valid;
    logic        cfg_issue_ready;
    logic [2:0]  cfg_type;
    logic [1:0]  cfg_rca_id;
    logic [31:0] cfg_rs1;
    logic [31:0] cfg_rs2;
    logic        cfg_flush;
    logic        cfg_wr_valid;
    logic        cfg_wr_ready;
    logic [2:0]  cfg_wr_type;
    logic [1:0]  cfg_wr_rca_id;
    logic [31:0] cfg_wr_addr;
    logic [31:0] cfg_wr_data;
    logic [1:0]  use_check_id;
    logic        use_blocked;
    logic [2:0]  rca_pending_mask;
    logic        cfg_type_error;

    rca_config_sequencer #(.NUM_RCAS(NR), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_issue_valid  (cfg_issue_valid),
        .cfg_issue_ready  (cfg_issue_ready),
        .cfg_type         (cfg_type),
        .cfg_rca_id       (cfg_rca_id),
        .cfg_rs1          (cfg_rs1),
        .cfg_rs2          (cfg_rs2),
        .cfg_flush        (cfg_flush),
        .cfg_wr_valid     (cfg_wr_valid),
        .cfg_wr_ready     (cfg_wr_ready),
        .cfg_wr_type      (cfg_wr_type),
        .cfg_wr_rca_id    (cfg_wr_rca_id),
        .cfg_wr_addr      (cfg_wr_addr),
        .cfg_wr_data      (cfg_wr_data),
        .use_check_id     (use_check_id),
        .use_blocked      (use_blocked),
        .rca_pending_mask (rca_pending_mask),
        .cfg_type_error   (cfg_type_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t exp_q[$];
    bit   exp_err;
    int   tests;
    int   fails;

    function automatic bit is_legal(input logic [2:0] t, input logic [1:0] id);
        return (t >= 3'd2) && (int'(id) < NR);
    endfunction

    function automatic int pend(input logic [1:0] id);
        int n = 0;
        foreach (exp_q[k]) if (exp_q[k].id == id) n++;
        return n;
    endfunction

    function automatic logic [2:0] exp_mask();
        logic [2:0] m;
        for (int i = 0; i < NR; i++) m[i] = (pend(2'(i)) != 0);
        return m;
    endfunction

    task automatic drive(input logic v, input logic [2:0] t, input logic [1:0] id,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic fl, input logic wr, input logic [1:0] uc);
        cfg_issue_valid = v;
        cfg_type        = t;
        cfg_rca_id      = id;
        cfg_rs1         = a;
        cfg_rs2         = d;
        cfg_flush       = fl;
        cfg_wr_ready    = wr;
        use_check_id    = uc;
        #1;
    endtask

    // Applies the rules of one clock edge to the model using the driven inputs.
    task automatic model_update();
        bit hs;
        bit acc;
        bit err_n;
        ent_t e;
        hs    = (exp_q.size() > 0) && cfg_wr_ready;
        acc   = cfg_issue_valid && (exp_q.size() < CAP) && !cfg_flush;
        err_n = 1'b0;
        if (hs) void'(exp_q.pop_front());
        if (acc) begin
            if (is_legal(cfg_type, cfg_rca_id)) begin
                e.t = cfg_type; e.id = cfg_rca_id; e.a = cfg_rs1; e.d = cfg_rs2;
                exp_q.push_back(e);
            end else begin
                err_n = 1'b1;
            end
        end
        if (cfg_flush) exp_q.delete();
        exp_err = err_n;
    endtask

    task automatic advance();
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        tests++; if (cfg_wr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", cfg_wr_valid); end
        tests++; if (rca_pending_mask !== 3'b000) begin fails++; $display("FAIL reset_mask got=%b exp=000", rca_pending_mask); end
        tests++; if (cfg_type_error !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", cfg_type_error); end
        tests++; if (cfg_issue_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", cfg_issue_ready); end
        tests++; if (cfg_wr_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", cfg_wr_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic test_single();
        drive(1, 3'd3, 2'd1, 32'h10, 32'hAB, 0, 1, 2'd1);
        tests++; if (cfg_issue_ready !== 1'b1) begin fails++; $display("FAIL single_ready got=%b exp=1", cfg_issue_ready); end
        advance();
        tests++; if (cfg_wr_valid !== 1'b1) begin fails++; $display("FAIL single_valid got=%b exp=1", cfg_wr_valid); end
        tests++; if ({cfg_wr_type, cfg_wr_rca_id, cfg_wr_addr, cfg_wr_data} !== {3'd3, 2'd1, 32'h10, 32'hAB})
            begin fails++; $display("FAIL single_payload got=%0d/%0d/%h/%h exp=3/1/10/ab", cfg_wr_type, cfg_wr_rca_id, cfg_wr_addr, cfg_wr_data); end
        tests++; if (rca_pending_mask !== 3'b010) begin fails++; $display("FAIL single_mask got=%b exp=010", rca_pending_mask); end
        drive(0, 3'd0, 2'd0, 0, 0, 0, 1, 2'd1);
        tests++; if (use_blocked !== 1'b1) begin fails++; $display("FAIL single_blocked got=%b exp=1", use_blocked); end
        advance();
        tests++; if (cfg_wr_valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop got=%b exp=0", cfg_wr_valid); end
        tests++; if (rca_pending_mask !== 3'b000) begin fails++; $display("FAIL single_mask_clear got=%b exp=000", rca_pending_mask); end
        tests++; if (use_blocked !== 1'b0) begin fails++; $display("FAIL single_unblocked got=%b exp=0", use_blocked); end
    endtask

    task automatic test_capacity();
        for (int i = 0; i < 6; i++) begin
            drive(1, 3'(2 + (i % 6)), 2'(i % 3), 32'(i), 32'hC000 + 32'(i), 0, 0, 2'd0);
            tests++; if (cfg_issue_ready !== (i < CAP)) begin fails++; $display("FAIL cap_ready[%0d] got=%b exp=%b", i, cfg_issue_ready, i < CAP); end
            advance();
        end
        tests++; if (rca_pending_mask !== 3'b111) begin fails++; $display("FAIL cap_mask got=%b exp=111", rca_pending_mask); end
        for (int k = 0; k < CAP; k++) begin
            drive(0, 3'd0, 2'd0, 0, 0, 0, 1, 2'd0);
            tests++; if (cfg_wr_valid !== 1'b1 || cfg_wr_addr !== 32'(k) || cfg_wr_data !== 32'hC000 + 32'(k))
                begin fails++; $display("FAIL cap_drain[%0d] got valid=%b addr=%h data=%h exp addr=%h", k, cfg_wr_valid, cfg_wr_addr, cfg_wr_data, k); end
            advance();
        end
        tests++; if (cfg_wr_valid !== 1'b0) begin fails++; $display("FAIL cap_empty got=%b exp=0", cfg_wr_valid); end
        tests++; if (rca_pending_mask !== 3'b000) begin fails++; $display("FAIL cap_mask_clear got=%b exp=000", rca_pending_mask); end
    endtask

    task automatic test_same_cycle();
        drive(1, 3'd4, 2'd0, 32'hA0, 32'h1, 0, 0, 2'd0);
        advance();
        tests++; if (use_blocked !== 1'b1) begin fails++; $display("FAIL same_blocked_pre got=%b exp=1", use_blocked); end
        drive(1, 3'd5, 2'd0, 32'hB0, 32'h2, 0, 1, 2'd0);
        advance();
        tests++; if (rca_pending_mask !== 3'b001) begin fails++; $display("FAIL same_mask got=%b exp=001", rca_pending_mask); end
        tests++; if (use_blocked !== 1'b1) begin fails++; $display("FAIL same_blocked got=%b exp=1", use_blocked); end
        tests++; if (cfg_wr_valid !== 1'b1 || cfg_wr_addr !== 32'hB0) begin fails++; $display("FAIL same_next got valid=%b addr=%h exp 1/b0", cfg_wr_valid, cfg_wr_addr); end
        drive(0, 3'd0, 2'd0, 0, 0, 0, 1, 2'd0);
        advance();
        tests++; if (use_blocked !== 1'b0 || rca_pending_mask !== 3'b000) begin fails++; $display("FAIL same_drain got blocked=%b mask=%b exp 0/000", use_blocked, rca_pending_mask); end
    endtask

    task automatic test_illegal();
        logic [2:0] bad_t [3] = '{3'd1, 3'd0, 3'd3};
        logic [1:0] bad_id [3] = '{2'd2, 2'd1, 2'd3};
        for (int i = 0; i < 3; i++) begin
            drive(1, bad_t[i], bad_id[i], 32'hDEAD, 32'hBEEF, 0, 1, bad_id[i]);
            advance();
            tests++; if (cfg_type_error !== 1'b1) begin fails++; $display("FAIL illegal_err[%0d] got=%b exp=1", i, cfg_type_error); end
            tests++; if (cfg_wr_valid !== 1'b0 || rca_pending_mask !== 3'b000) begin fails++; $display("FAIL illegal_quiet[%0d] got valid=%b mask=%b exp 0/000", i, cfg_wr_valid, rca_pending_mask); end
        end
        drive(0, 3'd0, 2'd0, 0, 0, 0, 1, 2'd0);
        advance();
        tests++; if (cfg_type_error !== 1'b0) begin fails++; $display("FAIL illegal_err_clear got=%b exp=0", cfg_type_error); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd6, 2'(i), 32'hE0 + 32'(i), 32'(i), 0, 0, 2'd0);
            advance();
        end
        tests++; if (cfg_wr_valid !== 1'b1 || rca_pending_mask !== 3'b111) begin fails++; $display("FAIL flush_pre got valid=%b mask=%b exp 1/111", cfg_wr_valid, rca_pending_mask); end
        drive(1, 3'd3, 2'd0, 32'h55, 32'h66, 1, 0, 2'd0);
        tests++; if (cfg_issue_ready !== 1'b0) begin fails++; $display("FAIL flush_ready_blocked got=%b exp=0", cfg_issue_ready); end
        advance();
        drive(0, 3'd0, 2'd0, 0, 0, 0, 0, 2'd0);
        tests++; if (cfg_wr_valid !== 1'b0 || rca_pending_mask !== 3'b000 || cfg_issue_ready !== 1'b1)
            begin fails++; $display("FAIL flush_post got valid=%b mask=%b ready=%b exp 0/000/1", cfg_wr_valid, rca_pending_mask, cfg_issue_ready); end
        drive(1, 3'd7, 2'd2, 32'hF0, 32'hF1, 0, 1, 2'd2);
        advance();
        tests++; if (cfg_wr_valid !== 1'b1 || cfg_wr_addr !== 32'hF0 || cfg_wr_rca_id !== 2'd2)
            begin fails++; $display("FAIL flush_repush got valid=%b addr=%h id=%0d exp 1/f0/2", cfg_wr_valid, cfg_wr_addr, cfg_wr_rca_id); end
        drive(0, 3'd0, 2'd0, 0, 0, 0, 1, 2'd0);
        advance();
        tests++; if (cfg_wr_valid !== 1'b0) begin fails++; $display("FAIL flush_repush_done got=%b exp=0", cfg_wr_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd2, 2'(i), 32'h70 + 32'(i), 32'h7, 0, 0, 2'd0);
            advance();
        end
        drive(0, 3'd0, 2'd0, 0, 0, 0, 1, 2'd0);
        model_update();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        #1;
        tests++; if (cfg_wr_valid !== 1'b0 || rca_pending_mask !== 3'b000 || cfg_wr_addr !== 32'h0)
            begin fails++; $display("FAIL areset_clear got valid=%b mask=%b addr=%h exp 0/000/0", cfg_wr_valid, rca_pending_mask, cfg_wr_addr); end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            tests++; if (cfg_wr_valid !== 1'b0 || rca_pending_mask !== 3'b000)
                begin fails++; $display("FAIL areset_stale[%0d] got valid=%b mask=%b exp 0/000", k, cfg_wr_valid, rca_pending_mask); end
            drive(0, 3'd0, 2'd0, 0, 0, 0, 1, 2'd0);
            advance();
        end
    endtask

    task automatic test_random();
        logic [2:0] t;
        logic [1:0] id;
        logic [1:0] uc;
        for (int c = 0; c < 400; c++) begin
            tests++; if (cfg_wr_valid !== (exp_q.size() > 0)) begin fails++; $display("FAIL rand_valid[%0d] got=%b exp=%b", c, cfg_wr_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                tests++; if ({cfg_wr_type, cfg_wr_rca_id, cfg_wr_addr, cfg_wr_data} !== {exp_q[0].t, exp_q[0].id, exp_q[0].a, exp_q[0].d})
                    begin fails++; $display("FAIL rand_payload[%0d] got=%0d/%0d/%h/%h exp=%0d/%0d/%h/%h", c, cfg_wr_type, cfg_wr_rca_id, cfg_wr_addr, cfg_wr_data, exp_q[0].t, exp_q[0].id, exp_q[0].a, exp_q[0].d); end
            end
            tests++; if (rca_pending_mask !== exp_mask()) begin fails++; $display("FAIL rand_mask[%0d] got=%b exp=%b", c, rca_pending_mask, exp_mask()); end
            tests++; if (cfg_type_error !== exp_err) begin fails++; $display("FAIL rand_err[%0d] got=%b exp=%b", c, cfg_type_error, exp_err); end
            t  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            id = ($urandom_range(0, 9) < 9) ? 2'($urandom_range(0, 2)) : 2'd3;
            uc = 2'($urandom_range(0, 2));
            drive(1'($urandom_range(0, 9) < 6), t, id, $urandom, $urandom,
                  1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 1)), uc);
            tests++; if (cfg_issue_ready !== ((exp_q.size() < CAP) && !cfg_flush)) begin fails++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, cfg_issue_ready, (exp_q.size() < CAP) && !cfg_flush); end
            tests++; if (use_blocked !== (pend(uc) != 0)) begin fails++; $display("FAIL rand_blocked[%0d] got=%b exp=%b", c, use_blocked, pend(uc) != 0); end
            advance();
        end
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        exp_err = 1'b0;
        rst_n   = 1'b0;
        cfg_issue_valid = 1'b0;
        cfg_type        = 3'd0;
        cfg_rca_id      = 2'd0;
        cfg_rs1         = 32'h0;
        cfg_rs2         = 32'h0;
        cfg_flush       = 1'b0;
        cfg_wr_ready    = 1'b0;
        use_check_id    = 2'd0;
        test_reset();
        test_single();
        test_capacity();
        test_same_cycle();
        test_illegal();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
